// File: rtl/sha256_pkg.sv
// Shared constants and types for the nonce search controller and its header fetcher.
// Latency: n/a. Backpressure: n/a.
package sha256_pkg;

    localparam int HDR_WORDS      = 20;
    localparam int MSG_WORDS      = HDR_WORDS - 1;
    // GO cycle, the cycle where the core's stale done is ignored, and WRITE
    localparam int NONCE_OVERHEAD = 3;

    localparam logic [31:0] SHA256_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MID_GO,
        ST_MID_WAIT,
        ST_NONCE_GO,
        ST_NONCE_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/header_fetch.sv
// Reads the 20 header words from memory and keeps words 0..18 as the core message.
// Latency: 21 cycles from go to done (20 addresses plus one read-latency cycle).
// Backpressure: none; memory is assumed to answer every read one cycle later.
module header_fetch
    import sha256_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] base,
    output logic              active,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              fetch_done,
    output logic [31:0]       message [MSG_WORDS]
);

    logic [4:0] cnt;
    logic [4:0] cap_idx;
    logic       cap_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            cnt     <= '0;
            cap_vld <= 1'b0;
            cap_idx <= '0;
            for (int i = 0; i < MSG_WORDS; i++) message[i] <= '0;
        end else begin
            cap_vld <= active;
            cap_idx <= cnt;
            if (go) begin
                active <= 1'b1;
                cnt    <= '0;
            end else if (active) begin
                if (cnt == 5'(HDR_WORDS - 1)) active <= 1'b0;
                cnt <= cnt + 5'd1;
            end
            // word 19 is the header's own nonce slot and is dropped
            if (cap_vld && cap_idx < 5'(MSG_WORDS)) message[cap_idx] <= rd_data;
        end
    end

    assign rd_addr    = base + ADDR_W'(cnt);
    assign fetch_done = cap_vld && (cap_idx == 5'(HDR_WORDS - 1));

endmodule

// File: rtl/nonce_search_ctrl.sv
// Fetches a block header, computes the midstate, then sweeps NUM_NONCES nonces through the core.
// Latency: 21-cycle fetch, then core latency + NONCE_OVERHEAD cycles per nonce; done one cycle after last WRITE.
// Backpressure: none; start ignored while busy. NONCE_EARLY_EXIT_EN stops the sweep at the first match.
module nonce_search_ctrl
    import sha256_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] header_addr,
    input  logic [ADDR_W-1:0] out_addr,
    input  logic [31:0]       nonce_base,
    input  logic [31:0]       target,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [31:0]       found_nonce,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data,
    output logic              sha_start,
    output logic              sha_first_or_sec,
    output logic [31:0]       sha_pre_hash [8],
    output logic [31:0]       sha_message [MSG_WORDS],
    output logic [31:0]       sha_nonce,
    input  logic              sha_done,
    input  logic [31:0]       sha_hash_val [8]
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] hdr_addr_q, out_addr_q;
    logic [31:0]       target_q;
    logic [31:0]       midstate [8];
    logic [8:0]        n;
    logic              wait_first;
    logic              fetch_active, fetch_done;
    logic [ADDR_W-1:0] fetch_addr;
    logic              hit, last, stop, core_ready;

    header_fetch #(.ADDR_W(ADDR_W)) u_fetch (
        .clk        (clk),
        .reset      (reset),
        .go         (state == ST_IDLE && start),
        .base       (hdr_addr_q),
        .active     (fetch_active),
        .rd_addr    (fetch_addr),
        .rd_data    (mem_rd_data),
        .fetch_done (fetch_done),
        .message    (sha_message)
    );

    assign hit        = sha_hash_val[0] < target_q;
    assign last       = n == 9'(NUM_NONCES - 1);
    // the core still shows the previous done in the cycle after start
    assign core_ready = sha_done && !wait_first;
`ifdef NONCE_EARLY_EXIT_EN
    assign stop = last || (hit && !found);
`else
    assign stop = last;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:       if (start) state_nx = ST_FETCH;
            ST_FETCH:      if (fetch_done) state_nx = ST_MID_GO;
            ST_MID_GO:     state_nx = ST_MID_WAIT;
            ST_MID_WAIT:   if (core_ready) state_nx = ST_NONCE_GO;
            ST_NONCE_GO:   state_nx = ST_NONCE_WAIT;
            ST_NONCE_WAIT: if (core_ready) state_nx = ST_WRITE;
            ST_WRITE:      state_nx = stop ? ST_DONE : ST_NONCE_GO;
            default:       state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_addr_q  <= '0;
            out_addr_q  <= '0;
            target_q    <= '0;
            n           <= '0;
            wait_first  <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            sha_nonce   <= '0;
            for (int i = 0; i < 8; i++) midstate[i] <= '0;
        end else begin
            wait_first <= (state == ST_MID_GO) || (state == ST_NONCE_GO);
            if (state == ST_IDLE && start) begin
                hdr_addr_q  <= header_addr;
                out_addr_q  <= out_addr;
                target_q    <= target;
                sha_nonce   <= nonce_base;
                n           <= '0;
                found       <= 1'b0;
                found_nonce <= '0;
            end
            if (state == ST_MID_WAIT && core_ready) begin
                for (int i = 0; i < 8; i++) midstate[i] <= sha_hash_val[i];
            end
            if (state == ST_WRITE) begin
                if (hit && !found) begin
                    found       <= 1'b1;
                    found_nonce <= sha_nonce;
                end
                if (!last) begin
                    n         <= n + 9'd1;
                    sha_nonce <= sha_nonce + 32'd1;
                end
            end
        end
    end

    always_comb begin
        busy             = !(state == ST_IDLE || state == ST_DONE);
        done             = state == ST_DONE;
        sha_start        = (state == ST_MID_GO) || (state == ST_NONCE_GO);
        sha_first_or_sec = state inside {ST_NONCE_GO, ST_NONCE_WAIT, ST_WRITE};
        mem_we           = state == ST_WRITE;
        mem_wr_data      = (state == ST_WRITE) ? sha_hash_val[0] : '0;
        mem_addr         = '0;
        if (fetch_active)           mem_addr = fetch_addr;
        else if (state == ST_WRITE) mem_addr = out_addr_q + ADDR_W'(n);
        for (int i = 0; i < 8; i++) sha_pre_hash[i] = sha_first_or_sec ? midstate[i] : SHA256_IV[i];
    end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl with a behavioural core stand-in and a write scoreboard.
module tb_nonce_search_ctrl;

    localparam int NN  = 16;
    localparam int LAT = 4;

    typedef logic [7:0][31:0]  h8_t;
    typedef logic [18:0][31:0] m19_t;

    localparam h8_t TB_IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                             32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] header_addr = '0, out_addr = '0;
    logic [31:0] nonce_base = '0, target = '0;
    logic        busy, done, found, mem_we, sha_start, sha_first_or_sec;
    logic [31:0] found_nonce, mem_wr_data, sha_nonce;
    logic [15:0] mem_addr;
    logic [31:0] mem_rd_data = '0;
    logic [31:0] sha_pre_hash [8];
    logic [31:0] sha_message [19];
    logic        sha_done;
    logic [31:0] sha_hash_val [8];

    logic [31:0] hmem [65536];
    int errors = 0;
    int checks = 0;
    int stab_bad = 0;

    always #5 clk = ~clk;

    nonce_search_ctrl #(.NUM_NONCES(NN), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .header_addr(header_addr), .out_addr(out_addr),
        .nonce_base(nonce_base), .target(target), .busy(busy), .done(done), .found(found),
        .found_nonce(found_nonce), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .sha_start(sha_start), .sha_first_or_sec(sha_first_or_sec),
        .sha_pre_hash(sha_pre_hash), .sha_message(sha_message), .sha_nonce(sha_nonce),
        .sha_done(sha_done), .sha_hash_val(sha_hash_val)
    );

    function automatic logic [31:0] mix(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = {a[24:0], a[31:25]} ^ b;
        return r * 32'h01000193 + 32'ha5a5a5a5;
    endfunction

    // stand-in compression: first block uses words 0..15, second uses 16..18 plus the nonce
    function automatic h8_t core_hash(input h8_t pre, input m19_t m, input logic [31:0] nonce, input logic sec);
        h8_t r;
        logic [31:0] acc, w;
        acc = 32'h5bd1e995;
        for (int j = 0; j < 20; j++) begin
            if ((sec && j >= 16) || (!sec && j < 16)) begin
                if (j == 19) w = nonce;
                else         w = m[j];
                acc = mix(acc, w ^ 32'(j));
            end
        end
        for (int i = 0; i < 8; i++) begin
            r[i] = mix(pre[i], acc ^ 32'(i));
            acc  = acc + r[i];
        end
        return r;
    endfunction

    always @(posedge clk) mem_rd_data <= hmem[mem_addr];

    // core stand-in: done stays high for one cycle after start, then LAT cycles low
    h8_t         cur_pre, lat_pre, c_res;
    m19_t        cur_msg, lat_msg;
    logic [31:0] lat_nonce;
    logic        lat_sec, c_phase, c_done;
    int          c_cnt;
    assign sha_done = c_done;

    always_comb begin
        for (int i = 0; i < 8; i++)  cur_pre[i] = sha_pre_hash[i];
        for (int j = 0; j < 19; j++) cur_msg[j] = sha_message[j];
    end

    always @(posedge clk) begin
        if (reset) begin
            c_done  <= 1'b1;
            c_phase <= 1'b0;
            c_cnt   <= 0;
            for (int i = 0; i < 8; i++) sha_hash_val[i] <= '0;
        end else begin
            if (c_phase || c_cnt != 0) begin
                if (cur_pre !== lat_pre || cur_msg !== lat_msg || sha_nonce !== lat_nonce ||
                    sha_first_or_sec !== lat_sec)
                    stab_bad <= stab_bad + 1;
            end
            if (sha_start && !c_phase && c_cnt == 0) begin
                lat_pre   <= cur_pre;
                lat_msg   <= cur_msg;
                lat_nonce <= sha_nonce;
                lat_sec   <= sha_first_or_sec;
                c_res     <= core_hash(cur_pre, cur_msg, sha_nonce, sha_first_or_sec);
                c_phase   <= 1'b1;
            end else if (c_phase) begin
                c_phase <= 1'b0;
                c_done  <= 1'b0;
                c_cnt   <= LAT;
            end else if (c_cnt != 0) begin
                c_cnt <= c_cnt - 1;
                if (c_cnt == 1) begin
                    c_done <= 1'b1;
                    for (int i = 0; i < 8; i++) sha_hash_val[i] <= c_res[i];
                end
            end
        end
    end

    task automatic set_header(input logic [15:0] hb);
        for (int k = 0; k < 20; k++) hmem[16'(hb + 16'(k))] = $urandom;
    endtask

    function automatic logic [31:0] model_h0(input logic [15:0] hb, input logic [31:0] non);
        m19_t m;
        h8_t  mid, h;
        for (int k = 0; k < 19; k++) m[k] = hmem[16'(hb + 16'(k))];
        mid = core_hash(TB_IV, m, 32'd0, 1'b0);
        h   = core_hash(mid, m, non, 1'b1);
        return h[0];
    endfunction

    task automatic run_search(input string name, input logic [15:0] hb, input logic [15:0] ob,
                              input logic [31:0] nb, input logic [31:0] tg, input bit inject);
        logic [15:0] eaddr [$];
        logic [31:0] edata [$];
        logic [15:0] ea;
        logic [31:0] ed, h0, efn;
        logic        ef;
        int c, go_c, gocnt, inj, done_cnt;
        ef = 1'b0; efn = '0;
        for (int i = 0; i < NN; i++) begin
            h0 = model_h0(hb, nb + 32'(i));
            eaddr.push_back(16'(ob + 16'(i)));
            edata.push_back(h0);
            if (h0 < tg && !ef) begin
                ef = 1'b1; efn = nb + 32'(i);
`ifdef NONCE_EARLY_EXIT_EN
                break;
`endif
            end
        end
        @(negedge clk);
        header_addr = hb; out_addr = ob; nonce_base = nb; target = tg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1; go_c = -1; gocnt = 0; inj = 0; done_cnt = 0;
        while (c < 4000 && done_cnt == 0) begin
            if (inj == 2) begin
                start = 1'b0; header_addr = hb; out_addr = ob; nonce_base = nb; target = tg; inj = 3;
            end
            if (inj == 1) begin
                start = 1'b1; header_addr = ~hb; out_addr = ~ob; nonce_base = ~nb; target = ~tg; inj = 2;
            end
            if (sha_start && go_c < 0) begin
                go_c = c;
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", name, busy); end
            end
            if (sha_start && sha_first_or_sec) begin
                gocnt++;
                if (inject && gocnt == 3 && inj == 0) inj = 1;
            end
            if (mem_we) begin
                checks++;
                if (eaddr.size() == 0) begin
                    errors++; $display("FAIL %s extra_write: got addr %h, no write expected", name, mem_addr);
                end else begin
                    ea = eaddr.pop_front(); ed = edata.pop_front();
                    if (mem_addr !== ea || mem_wr_data !== ed) begin
                        errors++;
                        $display("FAIL %s write: got %h=%h want %h=%h", name, mem_addr, mem_wr_data, ea, ed);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
            end else begin
                @(negedge clk);
                c++;
            end
        end
        checks++;
        if (done_cnt == 0) begin
            errors++; $display("FAIL %s timeout: no done after %0d cycles", name, c);
            return;
        end
        checks++;
        if (go_c != 22) begin errors++; $display("FAIL %s fetch_latency: got %0d want 22", name, go_c); end
        checks++;
        if (eaddr.size() != 0) begin errors++; $display("FAIL %s missing_writes: got %0d short want 0", name, eaddr.size()); end
        checks++;
        if (found !== ef) begin errors++; $display("FAIL %s found: got %b want %b", name, found, ef); end
        if (ef) begin
            checks++;
            if (found_nonce !== efn) begin errors++; $display("FAIL %s found_nonce: got %h want %h", name, found_nonce, efn); end
        end
        checks++;
        if (stab_bad != 0) begin errors++; $display("FAIL %s core_inputs_stable: got %0d changes want 0", name, stab_bad); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse: got done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset busy/done: got %b%b want 00", busy, done); end
        checks++;
        if (found !== 1'b0 || found_nonce !== '0) begin errors++; $display("FAIL reset found: got %b %h want 0 0", found, found_nonce); end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wr_data !== '0) begin
            errors++; $display("FAIL reset mem: got we=%b a=%h d=%h want 0", mem_we, mem_addr, mem_wr_data);
        end
        checks++;
        if (sha_start !== 1'b0 || sha_first_or_sec !== 1'b0 || sha_nonce !== '0) begin
            errors++; $display("FAIL reset sha: got %b %b %h want 0 0 0", sha_start, sha_first_or_sec, sha_nonce);
        end
    endtask

    task automatic test_basic();
        set_header(16'h0100);
        run_search("basic", 16'h0100, 16'h2000, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_found_all();
        run_search("found_all", 16'h0100, 16'h2000, 32'h0, 32'hffffffff, 1'b0);
    endtask

    task automatic test_wrap();
        set_header(16'hfff0);
        run_search("wrap", 16'hfff0, 16'hfff8, 32'hfffffffe, 32'h40000000, 1'b0);
    endtask

    task automatic test_target5();
        logic [31:0] t;
        set_header(16'h0300);
        t = model_h0(16'h0300, 32'h1000 + 32'd5) + 32'd1;
        run_search("target5", 16'h0300, 16'h0400, 32'h1000, t, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_search("start_ignored", 16'h0100, 16'h2100, 32'h77, 32'h80000000, 1'b1);
    endtask

    task automatic test_reset_mid();
        int c;
        logic [149:0] outs;
        @(negedge clk);
        header_addr = 16'h0100; out_addr = 16'h2000; nonce_base = 32'h0; target = 32'hffffffff; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        outs = {busy, done, found, mem_we, sha_start, sha_first_or_sec, found_nonce, mem_addr, mem_wr_data, sha_nonce};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_mid_fetch: got outputs %h want 0", outs); end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (c < 4000 && !(sha_start && sha_first_or_sec && sha_nonce == 32'd1)) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c >= 4000) begin errors++; $display("FAIL reset_mid_wait timeout: second nonce GO not seen in %0d cycles", c); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        outs = {busy, done, found, mem_we, sha_start, sha_first_or_sec, found_nonce, mem_addr, mem_wr_data, sha_nonce};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_mid_wait: got outputs %h want 0", outs); end
        run_search("after_reset", 16'h0100, 16'h2200, 32'h5, 32'h20000000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_found_all();
        test_wrap();
        test_target5();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nonce_search_ctrl.md
# nonce_search_ctrl

Initiator-side controller for the Bitcoin double-SHA-256 core. It fetches a 20-word block header from memory and runs the core once in first-block mode to obtain the midstate. It then sweeps a range of nonces, running the core in second-block mode for each nonce. Each resulting H0 word is written back to memory and compared against a target. The block sits between the system memory/host and the `sha_256` core, and owns the core's `start`/`done` handshake.

## Interface
- `NUM_NONCES`, 16: nonces per search; range 1..256.
- `ADDR_W`, 16: memory address width.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `header_addr`  in  ADDR_W  base address of the 20 header words.
- `out_addr`  in  ADDR_W  base address for the NUM_NONCES H0 results.
- `nonce_base`  in  32  first nonce.
- `target`  in  32  a match is H0 < target (unsigned).
- `busy`  out  1  high from accepted start until done.
- `done`  out  1  one-cycle pulse at end of search.
- `found`  out  1  a match occurred in the last search.
- `found_nonce`  out  32  first matching nonce.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_we`  out  1  write enable.
- `mem_wr_data`  out  32  write data.
- `mem_rd_data`  in  32  read data, valid the cycle after `mem_addr`.
- `sha_start`  out  1  core start pulse.
- `sha_first_or_sec`  out  1  0 = first block (message[0..15]); 1 = second block plus final hash.
- `sha_pre_hash[8]`  out  32 each  IV or midstate.
- `sha_message[19]`  out  32 each  header words 0..18.
- `sha_nonce`  out  32  current nonce.
- `sha_done`  in  1  core idle / result valid.
- `sha_hash_val[8]`  in  32 each  core result.

## Operation
- States:
  - IDLE → FETCH on `start`. The search parameters are latched, `found` is cleared and `busy` is set.
  - FETCH: issue addresses `header_addr`+0..19 on consecutive cycles and capture each word one cycle later into `sha_message`. Word 19 is the header nonce slot; it is read but discarded.
  - MID_GO: `sha_start`=1 for one cycle with `sha_first_or_sec`=0 and `sha_pre_hash`=the SHA-256 IV.
  - MID_WAIT: on `sha_done`, latch `sha_hash_val` as the midstate. Set n=0.
  - NONCE_GO: `sha_start`=1 for one cycle with `sha_first_or_sec`=1, `sha_pre_hash`=midstate and `sha_nonce`=`nonce_base`+n (mod 2^32).
  - NONCE_WAIT: on `sha_done`, go to WRITE.
  - WRITE: `mem_we`=1 for one cycle, `mem_addr`=`out_addr`+n, `mem_wr_data`=`sha_hash_val[0]`. If H0 < `target` and `found`=0, set `found` and `found_nonce`. If n=NUM_NONCES-1, go to DONE; otherwise n++ and go to NONCE_GO.
  - DONE: `done`=1 for one cycle and `busy`=0, then go to IDLE.
- `sha_done` is ignored in the cycle immediately after any `sha_start`, because the core drops `done` one cycle after start. The WAIT states act only on `sha_done`=1 from the second cycle onward.
- `start` while `busy` is ignored.
- `found`/`found_nonce` hold until the next accepted `start`.
- Address arithmetic wraps mod 2^ADDR_W.
- Reset mid-search returns to IDLE immediately with all outputs at their reset values. The core shares the system reset and is returned to its own idle state by it.
- Reset values: `busy`, `done`, `found`, `mem_we` and `sha_start` = 0; `found_nonce`, `mem_addr`, `mem_wr_data` and `sha_nonce` = 0; `sha_first_or_sec` = 0.

## Timing
- FETCH takes 21 cycles: 20 addresses, with the last capture one cycle after the last address.
- Per-nonce overhead is the core latency plus 3 cycles (GO, the ignored cycle, WRITE).
- `done` pulses in the cycle after the final WRITE.
- `mem_we` is never asserted during FETCH. Exactly one write per nonce.
- `sha_*` inputs to the core are held stable from the GO cycle until the WAIT state exits.

## Configuration
- `NONCE_EARLY_EXIT_EN` defined: the WRITE that sets `found` transitions directly to DONE. Later nonces are neither hashed nor written.
- Undefined: all NUM_NONCES nonces are always processed and written. `found_nonce` still reports the first match.

## Structure
- Package `sha256_pkg` contains:
  - the eight IV constants;
  - `HDR_WORDS`=20;
  - the state enum type;
  - the per-nonce overhead constant.
- Sub-module `header_fetch` owns the FETCH address counter, the one-cycle read-latency capture and the 19-word message register. It has its own start/done handshake.
- The top level contains the FSM, nonce counter, compare logic and output write.

## Test plan
- Random header, `nonce_base`=0, `target`=0 → 16 writes at `out_addr`+0..15, each equal to the software double-SHA-256 H0. `found`=0, `done` pulses once.
- Same header, `target`=32'hFFFFFFFF → `found`=1 and `found_nonce`=0. With `NONCE_EARLY_EXIT_EN`, exactly one write occurs; without it, 16 writes occur.
- `nonce_base`=32'hFFFFFFFE, NUM_NONCES=4 → nonces FFFFFFFE, FFFFFFFF, 0, 1 are hashed; results match the model.
- `target` set to model H0 of nonce 5 plus 1 → `found_nonce`=`nonce_base`+5 (given no earlier match).
- `start` pulsed during NONCE_WAIT → ignored; results are unchanged.
- `reset` asserted mid-FETCH and mid-NONCE_WAIT → next cycle is IDLE with all outputs at reset values. A new `start` completes correctly.
